// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - word input, ALU and result channels of the ALU op sequencer
interface alu_op_sequencer_if #(
    parameter int BITS_DATA = 8,
    parameter int BITS_OP   = 6
);
    // input word channel
    logic                 i_valid;
    logic                 o_ready;
    logic [BITS_DATA-1:0] i_data;
    logic                 i_abort;

    // ALU side
    logic [BITS_DATA-1:0] o_alu_a;
    logic [BITS_DATA-1:0] o_alu_b;
    logic [BITS_OP-1:0]   o_alu_op;
    logic [BITS_DATA-1:0] i_alu_result;

    // result channel
    logic [BITS_DATA-1:0] o_result;
    logic                 o_result_valid;
    logic                 i_result_ready;
    logic                 o_zero;
    logic                 o_neg;
    logic                 o_bad_op;

    // debug
    logic [2:0]           o_state;

    // sequencer view
    modport slave (
        input  i_valid, i_data, i_abort, i_alu_result, i_result_ready,
        output o_ready, o_alu_a, o_alu_b, o_alu_op,
        output o_result, o_result_valid, o_zero, o_neg, o_bad_op, o_state
    );

    // host / environment view
    modport master (
        output i_valid, i_data, i_abort, i_alu_result, i_result_ready,
        input  o_ready, o_alu_a, o_alu_b, o_alu_op,
        input  o_result, o_result_valid, o_zero, o_neg, o_bad_op, o_state
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - collects A, B, op words, drives the ALU and holds the flagged result
module alu_op_sequencer #(
    parameter int BITS_DATA = 8,
    parameter int BITS_OP   = 6
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    alu_op_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t               state;
    logic [BITS_DATA-1:0] alu_a;
    logic [BITS_DATA-1:0] alu_b;
    logic [BITS_OP-1:0]   alu_op;
    logic [BITS_DATA-1:0] result;
    logic                 zero;
    logic                 neg;
    logic                 bad_op;

    // The eight codes the ALU implements; anything else is flagged but still executed.
    function automatic logic op_is_bad(input logic [BITS_OP-1:0] op);
        logic bad;
        bad = 1'b1;
        case (op)
            BITS_OP'(6'b100000),   // add
            BITS_OP'(6'b100010),   // sub
            BITS_OP'(6'b100100),   // and
            BITS_OP'(6'b100101),   // or
            BITS_OP'(6'b100110),   // xor
            BITS_OP'(6'b000011),   // sra
            BITS_OP'(6'b000010),   // srl
            BITS_OP'(6'b100111):   // nor
                bad = 1'b0;
            default:
                bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Upper bits of the op word carry no meaning.
    generate
        if (BITS_DATA > BITS_OP) begin : g_unused_hi
            logic unused_data_hi;
            assign unused_data_hi = ^bus.i_data[BITS_DATA-1:BITS_OP];
        end
    endgenerate

    // Sequencer state, operand/op registers and result capture; abort wins over every other action.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_A;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            result <= '0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            bad_op <= 1'b0;
        end else if (bus.i_abort) begin
            state <= S_A;
        end else begin
            case (state)
                S_A: begin
                    if (bus.i_valid) begin
                        alu_a <= bus.i_data;
                        state <= S_B;
                    end
                end
                S_B: begin
                    if (bus.i_valid) begin
                        alu_b <= bus.i_data;
                        state <= S_OP;
                    end
                end
                S_OP: begin
                    if (bus.i_valid) begin
                        alu_op <= bus.i_data[BITS_OP-1:0];
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    result <= bus.i_alu_result;
                    zero   <= (bus.i_alu_result == '0);
                    neg    <= bus.i_alu_result[BITS_DATA-1];
                    bad_op <= op_is_bad(alu_op);
                    state  <= S_OUT;
                end
                S_OUT: begin
                    if (bus.i_result_ready) begin
                        state <= S_A;
                    end
                end
                default: begin
                    state <= S_A;
                end
            endcase
        end
    end

    // Handshake outputs decode the registered state only, so no input reaches them combinationally.
    assign bus.o_ready        = (state == S_A) || (state == S_B) || (state == S_OP);
    assign bus.o_result_valid = (state == S_OUT);

    assign bus.o_alu_a  = alu_a;
    assign bus.o_alu_b  = alu_b;
    assign bus.o_alu_op = alu_op;
    assign bus.o_result = result;
    assign bus.o_zero   = zero;
    assign bus.o_neg    = neg;
    assign bus.o_bad_op = bad_op;
    assign bus.o_state  = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with a behavioural ALU
module tb_alu_op_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.BITS_DATA(8), .BITS_OP(6)) bus ();

    alu_op_sequencer #(.BITS_DATA(8), .BITS_OP(6)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // behavioural ALU beside the sequencer
    logic [7:0] alu_r;
    always_comb begin
        alu_r = 8'h00;
        case (bus.o_alu_op)
            6'b100000: alu_r = bus.o_alu_a + bus.o_alu_b;
            6'b100010: alu_r = bus.o_alu_a - bus.o_alu_b;
            6'b100100: alu_r = bus.o_alu_a & bus.o_alu_b;
            6'b100101: alu_r = bus.o_alu_a | bus.o_alu_b;
            6'b100110: alu_r = bus.o_alu_a ^ bus.o_alu_b;
            6'b000011: alu_r = $signed(bus.o_alu_a) >>> bus.o_alu_b;
            6'b000010: alu_r = bus.o_alu_a >> bus.o_alu_b;
            6'b100111: alu_r = ~(bus.o_alu_a | bus.o_alu_b);
            default:   alu_r = 8'h00;
        endcase
    end
    assign bus.i_alu_result = alu_r;

    typedef struct packed {
        logic [7:0] res;
        logic       z;
        logic       n;
        logic       b;
    } exp_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every consumed result is popped and compared
    always @(negedge clk) begin
        if (rst_n && bus.o_result_valid && bus.i_result_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_result: got %02h with nothing expected", bus.o_result);
            end else begin
                mon_e = sb.pop_front();
                if ({bus.o_result, bus.o_zero, bus.o_neg, bus.o_bad_op} !== mon_e) begin
                    n_bad++;
                    $display("FAIL result: got res=%02h z=%0b n=%0b bad=%0b expected res=%02h z=%0b n=%0b bad=%0b",
                             bus.o_result, bus.o_zero, bus.o_neg, bus.o_bad_op,
                             mon_e.res, mon_e.z, mon_e.n, mon_e.b);
                end
            end
        end
    end

    // present one word; returns at posedge+1 after the accepting edge
    task automatic send(input logic [7:0] w);
        bit done;
        done = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = w;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.o_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        bus.i_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    // full operation with latency checks; ends at posedge+1
    task automatic run_op(input vec_t v);
        send(v.a);
        send(v.b);
        sb.push_back(v.e);
        send(v.op);
        @(negedge clk);
        chk("exec_state", 32'(bus.o_state), 3);
        chk("exec_valid", 32'(bus.o_result_valid), 0);
        @(negedge clk);
        chk("out_valid", 32'(bus.o_result_valid), 1);
        if (bus.i_result_ready) begin
            @(negedge clk);
            chk("ready_back", 32'(bus.o_ready), 1);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[9] = '{
        '{8'h05, 8'h03, 8'h20, '{8'h08, 1'b0, 1'b0, 1'b0}},
        '{8'h03, 8'h05, 8'h22, '{8'hFE, 1'b0, 1'b1, 1'b0}},
        '{8'h80, 8'h01, 8'h03, '{8'hC0, 1'b0, 1'b1, 1'b0}},
        '{8'h07, 8'h09, 8'h3F, '{8'h00, 1'b1, 1'b0, 1'b1}},
        '{8'hF0, 8'h3C, 8'h24, '{8'h30, 1'b0, 1'b0, 1'b0}},
        '{8'h0F, 8'hF0, 8'h27, '{8'h00, 1'b1, 1'b0, 1'b0}},
        '{8'h80, 8'h01, 8'h02, '{8'h40, 1'b0, 1'b0, 1'b0}},
        '{8'h01, 8'h01, 8'hE0, '{8'h02, 1'b0, 1'b0, 1'b0}},
        '{8'h0F, 8'h0F, 8'h25, '{8'h0F, 1'b0, 1'b0, 1'b0}}
    };

    initial begin
        bus.i_valid        = 1'b0;
        bus.i_data         = 8'h00;
        bus.i_abort        = 1'b0;
        bus.i_result_ready = 1'b1;

        // reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_state", 32'(bus.o_state), 0);
        chk("rst_ready", 32'(bus.o_ready), 1);
        chk("rst_valid", 32'(bus.o_result_valid), 0);
        chk("rst_data", {bus.o_alu_a, bus.o_alu_b, 2'b00, bus.o_alu_op, bus.o_result}, 0);
        chk("rst_flags", {bus.o_zero, bus.o_neg, bus.o_bad_op}, 0);
        @(posedge clk);
        #1;

        // directed operations
        foreach (vecs[i]) run_op(vecs[i]);

        // backpressure: XOR 0x10^0x0F = 0x1F held while 0x55 waits
        bus.i_result_ready = 1'b0;
        run_op('{8'h10, 8'h0F, 8'h26, '{8'h1F, 1'b0, 1'b0, 1'b0}});
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h55;
        repeat (4) begin
            @(negedge clk);
            chk("bp_ready", 32'(bus.o_ready), 0);
            chk("bp_state", 32'(bus.o_state), 4);
            chk("bp_result", 32'(bus.o_result), 32'h1F);
            chk("bp_alu_a", 32'(bus.o_alu_a), 32'h10);
        end
        @(posedge clk);
        #1 bus.i_result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_back_to_a", 32'(bus.o_state), 0);
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        @(negedge clk);
        chk("bp_a_accepted", 32'(bus.o_alu_a), 32'h55);
        chk("bp_state_b", 32'(bus.o_state), 1);
        @(posedge clk);
        #1;
        send(8'h02);
        sb.push_back('{8'h57, 1'b0, 1'b0, 1'b0});
        send(8'h20);
        repeat (3) @(posedge clk);
        #1;

        // abort in S_B, with a competing input word
        send(8'h11);
        bus.i_abort = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h99;
        @(posedge clk);
        #1;
        bus.i_abort = 1'b0;
        bus.i_valid = 1'b0;
        @(negedge clk);
        chk("abort_state", 32'(bus.o_state), 0);
        chk("abort_alu_a", 32'(bus.o_alu_a), 32'h11);
        chk("abort_alu_b", 32'(bus.o_alu_b), 32'h02);

        // abort in S_EXEC: no capture
        @(posedge clk);
        #1;
        send(8'h01);
        send(8'h01);
        send(8'h20);
        bus.i_abort = 1'b1;
        @(posedge clk);
        #1 bus.i_abort = 1'b0;
        @(negedge clk);
        chk("abort_exec_state", 32'(bus.o_state), 0);
        chk("abort_exec_valid", 32'(bus.o_result_valid), 0);
        chk("abort_exec_result", 32'(bus.o_result), 32'h57);
        repeat (3) @(posedge clk);
        #1;

        // asynchronous reset in the middle of S_EXEC
        send(8'h05);
        send(8'h03);
        send(8'h20);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_state", 32'(bus.o_state), 0);
        chk("areset_valid", 32'(bus.o_result_valid), 0);
        chk("areset_result", 32'(bus.o_result), 0);
        chk("areset_alu", {bus.o_alu_a, bus.o_alu_b, 2'b00, bus.o_alu_op}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
